// File: rtl/mem_access_stage.sv
// mem_access_stage: single-entry, in-order load/store stage between the ALU and writeback.
// Define MEM_TIMEOUT_EN to abort requests that are not granted within TIMEOUT_CYCLES.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  size_i,
    input  logic [63:0] instr_info_i,
    input  logic        flush_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic [63:0] wb_instr_info_o,
    output logic        misalign_o,
    output logic        mem_err_o,
    output logic [1:0]  dbg_state_o
);
    // ALU side: a transfer happens when alu_valid_i & alu_ready_o & !flush_i in the same cycle.
    // Memory side: dmem_req_o and its attributes stay stable until the cycle dmem_gnt_i is seen;
    // one dmem_rvalid_i follows each granted read, no earlier than the cycle after the grant.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
    state_t state, state_next;

    logic        accept, mem_op, misaligned, timeout, drop;
    logic [4:0]  op_rd;
    logic [63:0] op_info;
    logic        op_load;
    logic [2:0]  op_size;
    logic [1:0]  op_lsb;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, shifted, load_data;
    logic        fin, fin_we, fin_mis, fin_err, pulse;
    logic [31:0] fin_data;
    logic [4:0]  fin_rd;
    logic [63:0] fin_info;

    assign alu_ready_o = (state == IDLE);
    assign accept      = alu_valid_i & alu_ready_o & ~flush_i;
    assign mem_op      = is_load_i | is_store_i;
    assign dmem_req_o  = (state == REQ);
    assign dbg_state_o = state;

    always_comb begin
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = store_data_i;
        case (size_i[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << alu_result_i[1:0];
                wdata_calc = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                misaligned = alu_result_i[0];
                be_calc    = 4'b0011 << alu_result_i[1:0];
                wdata_calc = {2{store_data_i[15:0]}};
            end
            default: misaligned = |alu_result_i[1:0];
        endcase
    end

    always_comb begin
        shifted = dmem_rdata_i >> {op_lsb, 3'b000};
        case (op_size)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state == REQ && state_next == REQ)
            to_cnt <= to_cnt + 1'b1;
        else
            to_cnt <= '0;
    end

    assign timeout = (state == REQ) && !dmem_gnt_i && (to_cnt == TO_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        fin        = 1'b0;
        fin_we     = 1'b0;
        fin_mis    = 1'b0;
        fin_err    = 1'b0;
        fin_data   = wb_data_o;
        fin_rd     = op_rd;
        fin_info   = op_info;
        case (state)
            IDLE: begin
                if (accept) begin
                    fin_rd   = rd_i;
                    fin_info = instr_info_i;
                    fin_data = alu_result_i;
                    if (mem_op && !misaligned) begin
                        state_next = REQ;
                    end else begin
                        fin     = 1'b1;
                        fin_mis = mem_op;
                        fin_we  = !mem_op && (rd_i != 5'd0);
                    end
                end
            end
            REQ: begin
                // A granted load must still collect its response, even if flushed in the same cycle.
                if (dmem_gnt_i) begin
                    state_next = op_load ? WAIT : IDLE;
                    fin        = !op_load;
                end else if (flush_i) begin
                    state_next = IDLE;
                end else if (timeout) begin
                    state_next = IDLE;
                    fin        = 1'b1;
                    fin_err    = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_next = IDLE;
                    fin        = !drop;
                    fin_we     = (op_rd != 5'd0);
                    fin_data   = load_data;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pulse = fin & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_rd        <= '0;
            op_info      <= '0;
            op_load      <= 1'b0;
            op_size      <= '0;
            op_lsb       <= '0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            drop         <= 1'b0;
        end else begin
            if (accept) begin
                op_rd        <= rd_i;
                op_info      <= instr_info_i;
                op_load      <= is_load_i;
                op_size      <= size_i;
                op_lsb       <= alu_result_i[1:0];
                dmem_we_o    <= is_store_i;
                dmem_addr_o  <= {alu_result_i[31:2], 2'b00};
                dmem_be_o    <= be_calc;
                dmem_wdata_o <= wdata_calc;
            end
            drop <= (state_next == WAIT) && (drop || flush_i);
        end
    end

    // Data fields only move on a pulse; the qualifier flags are pulse-wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_o      <= 1'b0;
            wb_we_o         <= 1'b0;
            misalign_o      <= 1'b0;
            mem_err_o       <= 1'b0;
            wb_rd_o         <= '0;
            wb_data_o       <= '0;
            wb_instr_info_o <= '0;
        end else begin
            wb_valid_o <= pulse;
            wb_we_o    <= pulse & fin_we;
            misalign_o <= pulse & fin_mis;
            mem_err_o  <= pulse & fin_err;
            if (pulse) begin
                wb_rd_o         <= fin_rd;
                wb_data_o       <= fin_data;
                wb_instr_info_o <= fin_info;
            end
        end
    end
endmodule
